// File: rtl/pulse_train_generator_pkg.sv
// Shared types and helpers for the pulse train generator.
// Combinational helpers only; no state, no backpressure.
package pulse_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam int DEFAULT_CNT_W = 8;

    // A programmed length of 0 runs as 1 so that no phase can vanish.
    function automatic int unsigned len_min1(input int unsigned len);
        return (len == 0) ? 1 : len;
    endfunction

endpackage

// File: rtl/pulse_train_generator_if.sv
// Request and waveform bundle between a pulse train generator and its driver.
// Pure wiring; the driver sees busy as its only backpressure.
interface pulse_train_generator_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic [CNT_W-1:0] high_len;
    logic [CNT_W-1:0] low_len;
    logic [CNT_W-1:0] num_pulses;
    logic             abort;
    logic             signal_out;
    logic             busy;
    logic             done;

    modport master (
        output start, high_len, low_len, num_pulses, abort,
        input  signal_out, busy, done
    );

    modport slave (
        input  start, high_len, low_len, num_pulses, abort,
        output signal_out, busy, done
    );
endinterface

// File: rtl/pulse_train_generator_phase_timer.sv
// Loadable down-counter timing one HIGH or LOW phase; expire flags the last cycle.
// Load takes effect at the next edge; no backpressure, enable simply holds it.
module phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             expire
);

    logic [CNT_W-1:0] count;

    // Never steps below 1: the owner reloads on expire instead.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && !expire) begin
            count <= count - CNT_W'(1);
        end
    end

    assign expire = (count == CNT_W'(1));

endmodule

// File: rtl/pulse_train_generator.sv
// Emits N pulses of H cycles high / L cycles low after a start; all outputs registered.
// First high one cycle after accept; start is dropped while busy, abort cancels in one cycle.
module pulse_train_generator
    import pulse_gen_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic                     clk,
    input  logic                     reset_n,
    pulse_train_generator_if.slave   pt
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] h_len, h_len_nxt;
    logic [CNT_W-1:0] l_len, l_len_nxt;
    logic [CNT_W-1:0] rem_cnt, rem_cnt_nxt;
    logic             done_nxt;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_en;
    logic             tmr_expire;

    logic             signal_r;
    logic             busy_r;
    logic             done_r;

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_phase_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .expire   (tmr_expire)
    );

    always_comb begin
        state_nxt   = state;
        h_len_nxt   = h_len;
        l_len_nxt   = l_len;
        rem_cnt_nxt = rem_cnt;
        tmr_load    = 1'b0;
        tmr_val     = h_len;
        tmr_en      = 1'b0;
        done_nxt    = 1'b0;

        unique case (state)
            IDLE: begin
                if (pt.start) begin
                    h_len_nxt   = CNT_W'(len_min1(32'(pt.high_len)));
                    l_len_nxt   = CNT_W'(len_min1(32'(pt.low_len)));
                    rem_cnt_nxt = pt.num_pulses;
                    if (pt.num_pulses != '0) begin
                        state_nxt = HIGH;
                        tmr_load  = 1'b1;
                        tmr_val   = h_len_nxt;
                    end else begin
                        done_nxt  = 1'b1;
                    end
                end
            end
            HIGH: begin
                if (pt.abort) begin
                    state_nxt = IDLE;
                end else if (tmr_expire) begin
                    state_nxt = LOW;
                    tmr_load  = 1'b1;
                    tmr_val   = l_len;
                end else begin
                    tmr_en    = 1'b1;
                end
            end
            LOW: begin
                // Abort outranks the end-of-phase decision, so no done on cancel.
                if (pt.abort) begin
                    state_nxt = IDLE;
                end else if (tmr_expire) begin
                    if (rem_cnt > CNT_W'(1)) begin
                        rem_cnt_nxt = rem_cnt - CNT_W'(1);
                        state_nxt   = HIGH;
                        tmr_load    = 1'b1;
                        tmr_val     = h_len;
                    end else begin
                        state_nxt   = IDLE;
                        done_nxt    = 1'b1;
                    end
                end else begin
                    tmr_en    = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            h_len    <= '0;
            l_len    <= '0;
            rem_cnt  <= '0;
            signal_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state    <= state_nxt;
            h_len    <= h_len_nxt;
            l_len    <= l_len_nxt;
            rem_cnt  <= rem_cnt_nxt;
            signal_r <= (state_nxt == HIGH);
            busy_r   <= (state_nxt != IDLE);
            done_r   <= done_nxt;
        end
    end

    assign pt.signal_out = signal_r;
    assign pt.busy       = busy_r;
    assign pt.done       = done_r;

endmodule
